// File: rtl/stim_pkg.sv
// stim_pkg: shared types and idle constants for the stimulus player
package stim_pkg;
  localparam int SW_W_D = 10;
  localparam int KEY_W_D = 4;
  localparam int DLY_W_D = 8;
  localparam logic [SW_W_D-1:0] SW_IDLE = '0;
  localparam logic [KEY_W_D-1:0] KEY_IDLE_D = '1;
  typedef struct packed {
    logic [SW_W_D-1:0] sw;
    logic [KEY_W_D-1:0] key;
    logic [DLY_W_D-1:0] dly;
  } stim_entry_t;
  typedef enum logic [1:0] {IDLE, PLAY, FINISH} stim_state_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every TICK_DIV enabled cycles, restartable by clear
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = enable && cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk)
    if (clear || tick) cnt <= '0;
    else if (enable) cnt <= cnt + CW'(1);
endmodule

// File: rtl/stimulus_player.sv
// stimulus_player: replays a scripted SW/KEY sequence, holding each entry for a tick-based delay
module stimulus_player
  import stim_pkg::*;
#(
  parameter int SW_W = 10,
  parameter int KEY_W = 4,
  parameter int DEPTH = 16,
  parameter int DLY_W = 8,
  parameter int TICK_DIV = 25_000_000,
  parameter logic [KEY_W-1:0] KEY_IDLE = {KEY_W{1'b1}},
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic start,
  input  logic stop,
  input  logic loop_en,
  input  logic [AW:0] len,
  input  logic wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [SW_W-1:0] wr_sw,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [DLY_W-1:0] wr_dly,
  output logic [SW_W-1:0] sw_out,
  output logic [KEY_W-1:0] key_out,
  output logic busy,
  output logic done,
  output logic [AW-1:0] step_idx
);
  typedef struct packed {
    logic [SW_W-1:0] sw;
    logic [KEY_W-1:0] key;
    logic [DLY_W-1:0] dly;
  } entry_t;
  entry_t mem [DEPTH];
  stim_state_t state, nstate;
  logic [AW-1:0] idx, nidx;
  logic [AW:0] len_q, len_eff;
  logic [DLY_W-1:0] dcnt;
  logic tick, go, last, expire, load;
  assign len_eff = len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : len;
  assign go = start && !stop;
  assign last = {1'b0, idx} + (AW+1)'(1) >= len_q;
  assign expire = state == PLAY && (dcnt == '0 || (tick && dcnt == DLY_W'(1)));
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk(CLOCK_50),
    .clear(!resetn || state != PLAY || expire),
    .enable(state == PLAY),
    .tick(tick)
  );
  always_ff @(posedge CLOCK_50)
    if (wr_en && state == IDLE) mem[wr_addr] <= '{wr_sw, wr_key, wr_dly};
  always_comb begin
    nstate = state;
    nidx = idx;
    load = 1'b0;
    if (state == IDLE) begin
      if (go) begin
        nstate = len_eff == '0 ? FINISH : PLAY;
        nidx = '0;
        load = len_eff != '0;
      end
    end else if (stop || state == FINISH) nstate = IDLE;
    else if (expire) begin
      nstate = last && !loop_en ? FINISH : PLAY;
      nidx = last ? '0 : idx + AW'(1);
      load = !last || loop_en;
    end
  end
  always_ff @(posedge CLOCK_50)
    if (!resetn) begin
      state <= IDLE;
      idx <= '0;
      dcnt <= '0;
      len_q <= '0;
      sw_out <= '0;
      key_out <= KEY_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      step_idx <= '0;
    end else begin
      state <= nstate;
      idx <= nidx;
      dcnt <= load ? mem[nidx].dly : (tick && dcnt != '0) ? dcnt - DLY_W'(1) : dcnt;
      if (state == IDLE && go) len_q <= len_eff;
      sw_out <= nstate == PLAY ? mem[nidx].sw : '0;
      key_out <= nstate == PLAY ? mem[nidx].key : KEY_IDLE;
      busy <= nstate == PLAY;
      done <= nstate == FINISH;
      step_idx <= nstate == PLAY ? nidx : '0;
    end
endmodule

// File: doc/stimulus_player.md
# stimulus_player

Parametrised, synthesizable stimulus sequencer for the tile-matching game. It replays a scripted sequence of switch/key vectors into `tilegame`, holding each vector for a programmable number of prescaled ticks. It serves two roles: an on-board self-test source on the DE1-SoC and a reusable driver in simulation, replacing hand-timed `#delay` stimulus. It sits between the board I/O mux and `tilegame`'s SW/KEY inputs.

## Interface
Parameters:
- `SW_W`, 10, switch vector width
- `KEY_W`, 4, key vector width (keys active-low)
- `DEPTH`, 16, script entries; `AW` = clog2(DEPTH)
- `DLY_W`, 8, per-entry delay width, in ticks
- `TICK_DIV`, 25_000_000, clock cycles per tick; must be ≥1
- `KEY_IDLE`, all ones, key value when not playing

Ports:
- `CLOCK_50`  in  1  sole clock
- `resetn`  in  1  synchronous, active-low reset
- `start`  in  1  begin playback, sampled in IDLE only
- `stop`  in  1  abort playback
- `loop_en`  in  1  wrap to entry 0 after the last entry
- `len`  in  AW+1  number of entries to play; clamped to DEPTH
- `wr_en`  in  1  script write strobe
- `wr_addr`  in  AW  script write address
- `wr_sw`, `wr_key`, `wr_dly`  in  SW_W/KEY_W/DLY_W  entry contents
- `sw_out`  out  SW_W  driven switch vector
- `key_out`  out  KEY_W  driven key vector
- `busy`  out  1  playback active
- `done`  out  1  one-cycle pulse on normal completion
- `step_idx`  out  AW  index of the entry currently applied

## Operation
- FSM states: IDLE, PLAY, FINISH.
- **Reset** (`resetn`=0 at a clock edge):
  - State is IDLE; `sw_out`=0, `key_out`=KEY_IDLE, `busy`=0, `done`=0, `step_idx`=0, prescaler=0.
  - Script memory is not reset.
  - Reset mid-playback aborts immediately, with no `done` pulse.
- **Writes:** `wr_en` writes the entry at `wr_addr` in IDLE only. In PLAY or FINISH it is ignored.
- **IDLE → PLAY:** `start`=1, `stop`=0 and effective len ≥1.
  - idx=0, entry 0 applied, delay counter loaded with `wr_dly` of entry 0, prescaler cleared.
- **IDLE → FINISH:** `start`=1, `stop`=0 and len=0.
- **PLAY, entry i with delay D:**
  - Held for D·TICK_DIV cycles when D≥1; held exactly 1 cycle when D=0.
  - The prescaler restarts at every entry application.
  - A tick is asserted when prescaler = TICK_DIV−1; each tick decrements the delay counter.
  - The entry expires on the tick that takes the counter from 1 to 0, or immediately for D=0.
- **On expiry:**
  - If i < len−1: apply entry i+1.
  - Otherwise, if `loop_en`: apply entry 0. `loop_en` is sampled at the expiry cycle.
  - Otherwise: go to FINISH.
- **FINISH:** for one cycle, `done`=1, `sw_out`=0 and `key_out`=KEY_IDLE; then IDLE.
- **stop:** in PLAY or FINISH, go to IDLE next cycle with idle outputs and no `done`. `stop` wins over `start` and over an expiry in the same cycle.
- `start` while busy is ignored.
- `len` is sampled at start; later changes have no effect until the next start.
- `busy`=1 in PLAY only.

## Timing
- `start` sampled at edge t → entry 0 visible on `sw_out`/`key_out`, with `busy`=1, after edge t (registered, latency 1).
- The transition to the next entry is registered: outputs change at the edge following expiry detection, so each entry is held exactly as specified above.
- For a last entry expiring at edge e, `done` is high for the cycle after e and `busy` drops at the same edge.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Structure
- Package `stim_pkg`: `stim_entry_t` {sw, key, dly}, `stim_state_t` enum {IDLE, PLAY, FINISH}, idle-value constants.
- Sub-module `tick_prescaler` (parameter TICK_DIV):
  - Inputs: clear, enable. Output: tick.
  - Counter width clog2(TICK_DIV); TICK_DIV=1 ticks every enabled cycle.
- Script memory is an inferred register array, DEPTH × (SW_W+KEY_W+DLY_W), with a synchronous write port and an asynchronous read port indexed by idx.

## Test plan
Benches run with TICK_DIV=3.
- **Reset values:** hold `resetn`=0 for 2 cycles → `sw_out`=0, `key_out`=4'b1111, `busy`=0, `done`=0, `step_idx`=0.
- **Basic 3-entry playback:** script {SW=1, KEY=1101, D=2}, {SW=5, KEY=1111, D=1}, {SW=0, KEY=1110, D=0}; len=3; start.
  - SW=1 held 6 cycles, SW=5 held 3 cycles, KEY=1110 held 1 cycle.
  - `done` pulses once, then idle outputs.
- **Loop:** same script with `loop_en`=1 → after entry 2, entry 0 is reapplied and no `done` occurs. Dropping `loop_en` → `done` after the next pass.
- **Stop arbitration:** stop during entry 1 → IDLE next cycle, outputs 0/1111, no `done`. Stop and start in the same cycle in IDLE → stays IDLE.
- **Boundaries:**
  - len=0 start → `done` on the next cycle; `busy` stays 0.
  - len=DEPTH+5 → exactly DEPTH entries played.
  - wr_en during PLAY → memory unchanged.
- **Reset mid-playback:** `resetn`=0 during entry 1 → reset values next edge; memory retained; a later start replays from entry 0.
